// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 read/write traffic test: pattern FSM states
// and the data pattern used by both the generator and any readback checker.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT,
    READ,
    CHECK
  } pat_state_t;

  // High byte carries the pass number so stale data from an earlier pass is caught.
  function automatic logic [15:0] pattern(input logic [7:0] pass, input logic [7:0] idx);
    return {pass, idx};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing a slow level signal into a clock
// domain; asynchronous active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr3_rw_pattern.sv
// DDR3 test traffic generator: writes a pass-dependent burst into the controller
// write FIFO, waits, reads it back and scores every returned word.
module ddr3_rw_pattern
  import ddr3_test_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BURST_WORDS = 1024,
  parameter int WAIT_CYC    = 2048,
  parameter int CNT_W       = 16
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              init_calib_complete,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic              error,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              busy
);

  localparam int IDX_W  = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BURST_WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input logic [CNT_W-1:0] pass,
                                                 input logic [IDX_W-1:0] i);
    return DATA_W'(pattern(8'(pass), 8'(i)));
  endfunction

  logic              calib_s;
  pat_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              pass_inc;
  logic [CNT_W-1:0]  pass_nxt;
  logic              vld_p0;
  logic [IDX_W-1:0]  exp_idx_p0;
  logic              mismatch;

  sync_2ff #(.WIDTH(1)) u_calib_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (init_calib_complete),
    .q   (calib_s)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    pass_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (calib_s) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
        end
      end
      WRITE: begin
        if (idx == IDX_LAST) begin
          state_nxt = WAIT;
          wcnt_nxt  = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      WAIT: begin
        if (wcnt == WCNT_LAST) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      READ: begin
        if (idx == IDX_LAST) state_nxt = CHECK;
        else                 idx_nxt   = idx + 1'b1;
      end
      CHECK: begin
        state_nxt = WRITE;
        idx_nxt   = '0;
        pass_inc  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Losing calibration overrides everything; an interrupted pass is not counted.
    if (!calib_s) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      pass_inc  = 1'b0;
    end
    pass_nxt = pass_inc ? pass_cnt + 1'b1 : pass_cnt;
  end

  // Outputs are registered from the next-state decision so they track the state exactly.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      pass_cnt <= '0;
    end else begin
      wr_en    <= (state_nxt == WRITE);
      wr_data  <= (state_nxt == WRITE) ? word_of(pass_nxt, idx_nxt) : '0;
      rd_req   <= (state_nxt == READ);
      pass_cnt <= pass_nxt;
    end
  end

  assign busy = (state != IDLE);

  // Stage p0: FIFO pops the word; remember which index it should be
  always_ff @(posedge clk_50m) begin
    exp_idx_p0 <= idx;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      error   <= 1'b0;
      err_cnt <= '0;
    end else begin
      vld_p0 <= rd_req && calib_s;
      if (vld_p0 && calib_s && mismatch) begin
        error   <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  // Stage p1: returned word is on rd_data; score it against the current pass
  assign mismatch = (rd_data != word_of(pass_cnt, exp_idx_p0));

endmodule

// File: tb/tb_ddr3_rw_pattern.sv
// Bench for ddr3_rw_pattern: three instances with loopback FIFO models covering
// the full-size pass, counter saturation/wrap, and the minimal burst configuration.
module tb_ddr3_rw_pattern;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: default parameters
  logic        calib_m = 1'b0, flush_m = 1'b0;
  logic        wr_en_m, rd_req_m, error_m, busy_m;
  logic [15:0] wr_data_m, err_cnt_m, pass_cnt_m;
  logic [15:0] rd_data_m = '0;
  logic [15:0] q_m[$];
  logic [15:0] w_m;
  int          pops_m = 0;

  ddr3_rw_pattern dut_m (
    .clk_50m(clk), .rst(rst), .init_calib_complete(calib_m),
    .wr_en(wr_en_m), .wr_data(wr_data_m), .rd_req(rd_req_m), .rd_data(rd_data_m),
    .error(error_m), .err_cnt(err_cnt_m), .pass_cnt(pass_cnt_m), .busy(busy_m)
  );

  always @(posedge clk) begin
    if (flush_m) q_m.delete();
    else begin
      if (wr_en_m) q_m.push_back(wr_data_m);
      if (rd_req_m) begin
        w_m = 16'hDEAD;
        if (q_m.size() > 0) w_m = q_m.pop_front();
        rd_data_m <= (pops_m == 5) ? w_m - 16'd1 : w_m;
        pops_m++;
      end
    end
  end

  // Small instance: 8-bit counters, every returned word corrupted
  logic        calib_s = 1'b0;
  logic        wr_en_s, rd_req_s, error_s, busy_s;
  logic [15:0] wr_data_s;
  logic [7:0]  err_cnt_s, pass_cnt_s;
  logic [15:0] rd_data_s = '0;
  logic [15:0] q_s[$];
  logic [15:0] w_s;

  ddr3_rw_pattern #(.DATA_W(16), .BURST_WORDS(16), .WAIT_CYC(4), .CNT_W(8)) dut_s (
    .clk_50m(clk), .rst(rst), .init_calib_complete(calib_s),
    .wr_en(wr_en_s), .wr_data(wr_data_s), .rd_req(rd_req_s), .rd_data(rd_data_s),
    .error(error_s), .err_cnt(err_cnt_s), .pass_cnt(pass_cnt_s), .busy(busy_s)
  );

  always @(posedge clk) begin
    if (wr_en_s) q_s.push_back(wr_data_s);
    if (rd_req_s) begin
      w_s = 16'hDEAD;
      if (q_s.size() > 0) w_s = q_s.pop_front();
      rd_data_s <= ~w_s;
    end
  end

  // Tiny instance: two-word bursts, last word of pass 0 corrupted
  logic        calib_t = 1'b0;
  logic        wr_en_t, rd_req_t, error_t, busy_t;
  logic [15:0] wr_data_t, err_cnt_t, pass_cnt_t;
  logic [15:0] rd_data_t = '0;
  logic [15:0] q_t[$];
  logic [15:0] w_t;
  int          pops_t = 0;

  ddr3_rw_pattern #(.DATA_W(16), .BURST_WORDS(2), .WAIT_CYC(1), .CNT_W(16)) dut_t (
    .clk_50m(clk), .rst(rst), .init_calib_complete(calib_t),
    .wr_en(wr_en_t), .wr_data(wr_data_t), .rd_req(rd_req_t), .rd_data(rd_data_t),
    .error(error_t), .err_cnt(err_cnt_t), .pass_cnt(pass_cnt_t), .busy(busy_t)
  );

  always @(posedge clk) begin
    if (wr_en_t) q_t.push_back(wr_data_t);
    if (rd_req_t) begin
      w_t = 16'hDEAD;
      if (q_t.size() > 0) w_t = q_t.pop_front();
      rd_data_t <= (pops_t == 1) ? w_t ^ 16'h0001 : w_t;
      pops_t++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam int PASS_M = 2 * 1024 + 2048 + 1;
  localparam int PASS_S = 2 * 16 + 4 + 1;

  int t0, t2, d, t3, cs, t0s, ct, t0t;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",    wr_en_m,    0);
    check("rst_wr_data",  wr_data_m,  0);
    check("rst_rd_req",   rd_req_m,   0);
    check("rst_error",    error_m,    0);
    check("rst_err_cnt",  err_cnt_m,  0);
    check("rst_pass_cnt", pass_cnt_m, 0);
    check("rst_busy",     busy_m,     0);
    rst = 1'b0;

    // Calibration rises at cycle 10; first write three edges later
    go_to(10);
    calib_m = 1'b1;
    go_to(12);
    check("lat_wr_en_early", wr_en_m, 0);
    go_to(13);
    t0 = 13;
    check("first_wr_en",   wr_en_m,   1);
    check("first_wr_data", wr_data_m, 16'h0000);
    check("first_busy",    busy_m,    1);
    go_to(t0 + 1023);
    check("last_wr_data", wr_data_m, 16'h00FF);
    check("last_wr_en",   wr_en_m,   1);
    go_to(t0 + 1024);
    check("wait_wr_en", wr_en_m, 0);
    go_to(t0 + 1024 + 2047);
    check("wait_rd_req", rd_req_m, 0);
    go_to(t0 + 3072);
    check("first_rd_req", rd_req_m, 1);

    // Word 5 of pass 0 comes back as 0x0004
    go_to(t0 + 3078);
    check("err_before", error_m, 0);
    go_to(t0 + 3079);
    check("err_set",     error_m,   1);
    check("err_cnt_one", err_cnt_m, 1);
    go_to(t0 + 4096);
    check("check_rd_req", rd_req_m,   0);
    check("check_pass",   pass_cnt_m, 0);
    go_to(t0 + PASS_M);
    check("pass1_cnt",  pass_cnt_m, 1);
    check("pass1_data", wr_data_m,  16'h0100);
    t2 = t0 + 2 * PASS_M;
    go_to(t2);
    check("pass2_cnt",     pass_cnt_m, 2);
    check("sticky_error",  error_m,    1);
    check("clean_err_cnt", err_cnt_m,  1);

    // Calibration loss while reading word 300 of pass 2
    d = t2 + 3072 + 300;
    go_to(d);
    check("drop_rd_req", rd_req_m, 1);
    calib_m = 1'b0;
    go_to(d + 2);
    check("drop_busy_d2", busy_m, 1);
    go_to(d + 3);
    check("drop_idle",   busy_m,   0);
    check("drop_rd_off", rd_req_m, 0);
    flush_m = 1'b1;
    go_to(d + 50);
    check("drop_err_cnt", err_cnt_m,  1);
    check("drop_pass",    pass_cnt_m, 2);
    flush_m = 1'b0;
    calib_m = 1'b1;
    go_to(d + 52);
    check("rearm_wr_early", wr_en_m, 0);
    t3 = d + 53;
    go_to(t3);
    check("rearm_wr_en",   wr_en_m,   1);
    check("rearm_wr_data", wr_data_m, 16'h0200);
    go_to(t3 + PASS_M);
    check("rearm_pass",    pass_cnt_m, 3);
    check("rearm_err_cnt", err_cnt_m,  1);
    check("rearm_data",    wr_data_m,  16'h0300);

    // Asynchronous reset in the middle of a write burst
    go_to(t3 + PASS_M + 100);
    check("pre_rst_wr_en", wr_en_m, 1);
    #5;
    rst = 1'b1;
    #1;
    check("arst_wr_en",    wr_en_m,    0);
    check("arst_wr_data",  wr_data_m,  0);
    check("arst_busy",     busy_m,     0);
    check("arst_error",    error_m,    0);
    check("arst_err_cnt",  err_cnt_m,  0);
    check("arst_pass_cnt", pass_cnt_m, 0);
    calib_m = 1'b0;
    flush_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation and wrap with 8-bit counters
    cs = cyc;
    calib_s = 1'b1;
    t0s = cs + 3;
    go_to(t0s);
    check("s_first_wr_en", wr_en_s, 1);
    go_to(t0s + 15 * PASS_S);
    check("s_err_240",  err_cnt_s,  8'd240);
    check("s_pass_15",  pass_cnt_s, 8'd15);
    go_to(t0s + 20 * PASS_S);
    check("s_err_sat",  err_cnt_s,  8'hFF);
    check("s_error",    error_s,    1);
    go_to(t0s + 255 * PASS_S);
    check("s_pass_255", pass_cnt_s, 8'd255);
    check("s_data_255", wr_data_s,  16'hFF00);
    check("s_err_hold", err_cnt_s,  8'hFF);
    go_to(t0s + 256 * PASS_S);
    check("s_pass_wrap", pass_cnt_s, 8'd0);
    check("s_data_wrap", wr_data_s,  16'h0000);
    calib_s = 1'b0;

    // Two-word bursts: six-cycle pass, final word scored in CHECK
    ct = cyc;
    calib_t = 1'b1;
    t0t = ct + 3;
    go_to(t0t);
    check("t_wr_en",    wr_en_t,   1);
    check("t_wr_data0", wr_data_t, 16'h0000);
    go_to(t0t + 1);
    check("t_wr_data1", wr_data_t, 16'h0001);
    go_to(t0t + 2);
    check("t_wait_wr",  wr_en_t,   0);
    check("t_wait_rd",  rd_req_t,  0);
    go_to(t0t + 3);
    check("t_rd0", rd_req_t, 1);
    go_to(t0t + 4);
    check("t_rd1", rd_req_t, 1);
    go_to(t0t + 5);
    check("t_check_rd",  rd_req_t, 0);
    check("t_check_err", error_t,  0);
    check("t_check_bsy", busy_t,   1);
    go_to(t0t + 6);
    check("t_last_err",   error_t,    1);
    check("t_last_cnt",   err_cnt_t,  1);
    check("t_pass1",      pass_cnt_t, 1);
    check("t_pass1_data", wr_data_t,  16'h0100);
    go_to(t0t + 12);
    check("t_pass2",     pass_cnt_t, 2);
    check("t_clean_cnt", err_cnt_t,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
